can_tx_scheduler: RTL and testbench
===================================

Name: can_tx_scheduler

Overview:
- Transmit-side scheduler for the CAN controller. Holds NUM_MB transmit mailboxes, each with an 11-bit ID, a 4-bit DLC and one data byte.
- Picks the pending mailbox with the highest CAN priority (lowest ID) and launches it into the frame transmitter.
- Interprets the transmitter's result: success, arbitration loss or error. Handles requeue, retry limit and abort, and reports per-mailbox completion or failure to the host side.

Parameters:
- NUM_MB, 4, number of mailboxes (2..8).
- MAX_RETRY, 8, error/no-ACK attempts allowed before a mailbox is failed (1..15).
- TIMEOUT_CYC, 4096, watchdog limit in cycles; used only when CAN_TX_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (clears when rst==0 at posedge clk)
- load_valid  in  1  write mailbox load_idx this cycle
- load_idx  in  3  target mailbox index
- load_id  in  11  message ID
- load_dlc  in  4  DLC
- load_data  in  8  data byte
- load_err  out  1  one-cycle pulse: load rejected
- abort_req  in  NUM_MB  per-mailbox abort request (level, sampled each cycle)
- mb_pending  out  NUM_MB  mailbox holds an unsent frame
- mb_done  out  NUM_MB  one-cycle pulse: frame sent and ACKed
- mb_fail  out  NUM_MB  one-cycle pulse: retry limit reached or aborted
- tx_ready  in  1  transmitter idle, can accept a frame
- tx_start  out  1  one-cycle launch strobe
- tx_id  out  11  ID of in-flight frame
- tx_dlc  out  4  DLC of in-flight frame
- tx_data  out  8  data of in-flight frame
- tx_done  in  1  one-cycle pulse: attempt finished
- tx_ack_ok  in  1  qualifies tx_done: ACK received
- tx_arb_lost  in  1  qualifies tx_done: arbitration lost
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all of the following clear to 0: mb_pending, retry counters, load_err, mb_done, mb_fail, tx_start, tx_id, tx_dlc, tx_data, busy. State goes to IDLE.
- Reset mid-frame drops the in-flight frame silently; no mb_fail is pulsed.
- Load:
  - load_valid with load_idx >= NUM_MB pulses load_err and writes nothing.
  - Load to the in-flight mailbox pulses load_err; its contents are untouched.
  - Otherwise the mailbox contents are written, its retry count clears and mb_pending is set at the next edge, overwriting any unsent frame.
- FSM states: IDLE, SELECT, LAUNCH, WAIT_RESULT.
  - IDLE -> SELECT when any mb_pending bit is set.
  - SELECT (1 cycle): register the winner, i.e. the minimum ID among pending mailboxes; an ID tie goes to the lower index. Mark the winner in-flight and drive tx_id/tx_dlc/tx_data. If nothing is pending (an abort arrived meanwhile), return to IDLE.
  - LAUNCH: wait for tx_ready==1, then assert tx_start for exactly one cycle and go to WAIT_RESULT. tx_id/tx_dlc/tx_data stay stable from SELECT until tx_done.
  - WAIT_RESULT, on tx_done:
    - tx_ack_ok=1: clear pending, pulse mb_done[i].
    - tx_arb_lost=1: requeue with no retry increment.
    - Otherwise (no ACK or CRC error): retry+1. When retry reaches MAX_RETRY, clear pending and pulse mb_fail[i]; else requeue.
    - All outcomes go to IDLE, so the next attempt re-arbitrates among all pending mailboxes.
  - If tx_ack_ok and tx_arb_lost are both set, tx_ack_ok wins.
- Abort:
  - On a pending, non-in-flight mailbox: clear pending and pulse mb_fail the next cycle.
  - On the in-flight mailbox: deferred to tx_done. Success reports mb_done and the abort is dropped; any other outcome clears pending and pulses mb_fail regardless of retry count.
- Simultaneous events:
  - A load to a mailbox other than the in-flight one in the same cycle as tx_done: both take effect.
  - A load and an abort to the same mailbox in the same cycle: the load wins.
- Latency:
  - A load into an idle scheduler produces tx_start 3 cycles later (pending, SELECT, LAUNCH), given tx_ready=1.
  - tx_done to the mb_done/mb_fail pulse: 1 cycle.
- busy is high in every state except IDLE.

Optional Feature:
- CAN_TX_TIMEOUT_EN defined:
  - A 12-bit watchdog counts cycles in WAIT_RESULT.
  - If it reaches TIMEOUT_CYC with no tx_done, the attempt is treated as an error: retry+1, with the limit rule applied, then go to IDLE.
  - The counter clears on entry to WAIT_RESULT.
- Not defined: no counter; WAIT_RESULT waits indefinitely for tx_done.

Test Plan:
- Load mb0 ID 0x123 and mb2 ID 0x0A5 in the same idle period, tx_ready=1 -> first tx_start carries tx_id=0x0A5. After tx_done with ack -> mb_done[2] pulse, then tx_start with 0x123.
- mb1 ID 0x200 in flight, tx_done with tx_arb_lost -> no retry increment, mb1 relaunched. Repeat 20 times -> never fails.
- mb0 with MAX_RETRY=8, tx_done with ack=0 eight times -> mb_fail[0] pulses on the 8th attempt only, and mb_pending[0]=0.
- Load to the in-flight index -> load_err=1 for one cycle, tx_id unchanged. Load to idx 5 with NUM_MB=4 -> load_err.
- abort_req[3] while mb3 pending but not in flight -> mb_fail[3] the next cycle. Abort of the in-flight mailbox followed by a successful tx_done -> mb_done only.
- rst=0 during WAIT_RESULT -> all outputs 0 the next cycle, no fail pulse. With CAN_TX_TIMEOUT_EN and TIMEOUT_CYC=16, withhold tx_done -> relaunch after 16 cycles with retry=1.

Source files
------------

// File: rtl/can_tx_scheduler.sv
// Transmit-side scheduler for the CAN controller: holds NUM_MB mailboxes, launches the
// lowest-ID pending frame, and resolves success / arbitration loss / error with retry
// and abort handling. Optional watchdog in WAIT_RESULT under macro CAN_TX_TIMEOUT_EN.
module can_tx_scheduler #(
  parameter int unsigned NUM_MB      = 4,
  parameter int unsigned MAX_RETRY   = 8,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [2:0]        load_idx,
  input  logic [10:0]       load_id,
  input  logic [3:0]        load_dlc,
  input  logic [7:0]        load_data,
  output logic              load_err,
  input  logic [NUM_MB-1:0] abort_req,
  output logic [NUM_MB-1:0] mb_pending,
  output logic [NUM_MB-1:0] mb_done,
  output logic [NUM_MB-1:0] mb_fail,
  input  logic              tx_ready,
  output logic              tx_start,
  output logic [10:0]       tx_id,
  output logic [3:0]        tx_dlc,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  input  logic              tx_ack_ok,
  input  logic              tx_arb_lost,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSelect, StLaunch, StWait} state_e;

  state_e            state_q, state_d;
  logic [10:0]       id_q    [NUM_MB];
  logic [10:0]       id_d    [NUM_MB];
  logic [3:0]        dlc_q   [NUM_MB];
  logic [3:0]        dlc_d   [NUM_MB];
  logic [7:0]        data_q  [NUM_MB];
  logic [7:0]        data_d  [NUM_MB];
  logic [3:0]        retry_q [NUM_MB];
  logic [3:0]        retry_d [NUM_MB];
  logic [NUM_MB-1:0] pending_q, pending_d, done_q, done_d, fail_q, fail_d;
  logic              inflight_q, inflight_d, abort_defer_q, abort_defer_d;
  logic [2:0]        cur_q, cur_d;
  logic [10:0]       tx_id_q, tx_id_d;
  logic [3:0]        tx_dlc_q, tx_dlc_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d, load_err_q, load_err_d;
`ifdef CAN_TX_TIMEOUT_EN
  logic [11:0]       wd_q, wd_d;
`endif

  logic [NUM_MB-1:0] load_hit, elig;
  logic              win_found;
  logic [2:0]        win_idx;
  logic [10:0]       win_id;
  logic [3:0]        win_dlc;
  logic [7:0]        win_data;
  logic              coll_valid;
  logic [2:0]        coll_idx;
  logic              res_ok, res_arb, res_err;
  logic [3:0]        retry_inc;

  // Decode load target; a same-cycle load to a mailbox overrides its abort.
  always_comb begin
    for (int i = 0; i < NUM_MB; i++) load_hit[i] = load_valid && (load_idx == 3'(i));
    elig = pending_q & ~(abort_req & ~load_hit);
  end

  // Arbitration: lowest ID wins, strict compare keeps the lower index on a tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    win_id    = 11'h7ff;
    win_dlc   = 4'd0;
    win_data  = 8'd0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (elig[i] && (!win_found || id_q[i] < win_id)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
        win_id    = id_q[i];
        win_dlc   = dlc_q[i];
        win_data  = data_q[i];
      end
    end
  end

  // The SELECT winner already counts as in flight so a load cannot race its capture.
  always_comb begin
    coll_valid = inflight_q || (state_q == StSelect && win_found);
    coll_idx   = inflight_q ? cur_q : win_idx;
  end

  // Next-state: mailbox writes, aborts, FSM and attempt resolution.
  always_comb begin
    state_d       = state_q;
    id_d          = id_q;
    dlc_d         = dlc_q;
    data_d        = data_q;
    retry_d       = retry_q;
    pending_d     = pending_q;
    done_d        = '0;
    fail_d        = '0;
    inflight_d    = inflight_q;
    abort_defer_d = abort_defer_q;
    cur_d         = cur_q;
    tx_id_d       = tx_id_q;
    tx_dlc_d      = tx_dlc_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    load_err_d    = load_valid && (({29'd0, load_idx} >= NUM_MB) ||
                                   (coll_valid && load_idx == coll_idx));
    res_ok        = 1'b0;
    res_arb       = 1'b0;
    res_err       = 1'b0;
    retry_inc     = 4'd0;
`ifdef CAN_TX_TIMEOUT_EN
    wd_d          = wd_q;
`endif

    for (int i = 0; i < NUM_MB; i++) begin
      if (load_hit[i] && !(coll_valid && coll_idx == 3'(i))) begin
        id_d[i]      = load_id;
        dlc_d[i]     = load_dlc;
        data_d[i]    = load_data;
        retry_d[i]   = 4'd0;
        pending_d[i] = 1'b1;
      end else if (abort_req[i] && pending_q[i]) begin
        if (coll_valid && coll_idx == 3'(i)) begin
          abort_defer_d = 1'b1;  // resolved when the attempt finishes
        end else begin
          pending_d[i] = 1'b0;
          fail_d[i]    = 1'b1;
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|pending_q) state_d = StSelect;
      end
      StSelect: begin
        if (win_found) begin
          cur_d      = win_idx;
          inflight_d = 1'b1;
          tx_id_d    = win_id;
          tx_dlc_d   = win_dlc;
          tx_data_d  = win_data;
          state_d    = StLaunch;
        end else begin
          state_d = StIdle;
        end
      end
      StLaunch: begin
        if (tx_ready) begin
          tx_start_d = 1'b1;
          state_d    = StWait;
`ifdef CAN_TX_TIMEOUT_EN
          wd_d       = 12'd0;
`endif
        end
      end
      StWait: begin
        if (tx_done) begin
          if (tx_ack_ok)        res_ok  = 1'b1;
          else if (tx_arb_lost) res_arb = 1'b1;
          else                  res_err = 1'b1;
        end
`ifdef CAN_TX_TIMEOUT_EN
        if (!tx_done) begin
          if ({20'd0, wd_q} >= TIMEOUT_CYC - 1) res_err = 1'b1;
          else                                  wd_d    = wd_q + 12'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    if (res_ok || res_arb || res_err) begin
      for (int i = 0; i < NUM_MB; i++) begin
        if (3'(i) == cur_q) begin
          retry_inc = retry_q[i] + 4'd1;
          if (res_ok) begin
            pending_d[i] = 1'b0;
            done_d[i]    = 1'b1;
          end else begin
            if (res_err) retry_d[i] = retry_inc;
            if (abort_defer_q || abort_req[i] ||
                (res_err && {28'd0, retry_inc} >= MAX_RETRY)) begin
              pending_d[i] = 1'b0;
              fail_d[i]    = 1'b1;
            end
          end
        end
      end
      inflight_d    = 1'b0;
      abort_defer_d = 1'b0;
      state_d       = StIdle;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      for (int i = 0; i < NUM_MB; i++) begin
        id_q[i]    <= 11'd0;
        dlc_q[i]   <= 4'd0;
        data_q[i]  <= 8'd0;
        retry_q[i] <= 4'd0;
      end
      pending_q     <= '0;
      done_q        <= '0;
      fail_q        <= '0;
      inflight_q    <= 1'b0;
      abort_defer_q <= 1'b0;
      cur_q         <= 3'd0;
      tx_id_q       <= 11'd0;
      tx_dlc_q      <= 4'd0;
      tx_data_q     <= 8'd0;
      tx_start_q    <= 1'b0;
      load_err_q    <= 1'b0;
`ifdef CAN_TX_TIMEOUT_EN
      wd_q          <= 12'd0;
`endif
    end else begin
      state_q       <= state_d;
      id_q          <= id_d;
      dlc_q         <= dlc_d;
      data_q        <= data_d;
      retry_q       <= retry_d;
      pending_q     <= pending_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      inflight_q    <= inflight_d;
      abort_defer_q <= abort_defer_d;
      cur_q         <= cur_d;
      tx_id_q       <= tx_id_d;
      tx_dlc_q      <= tx_dlc_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      load_err_q    <= load_err_d;
`ifdef CAN_TX_TIMEOUT_EN
      wd_q          <= wd_d;
`endif
    end
  end

  assign mb_pending = pending_q;
  assign mb_done    = done_q;
  assign mb_fail    = fail_q;
  assign load_err   = load_err_q;
  assign tx_start   = tx_start_q;
  assign tx_id      = tx_id_q;
  assign tx_dlc     = tx_dlc_q;
  assign tx_data    = tx_data_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler: a load/arbitration vector table plus hand-written
// sequences for arbitration loss, retry limit, abort and mid-frame reset.
module tb_can_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [2:0]  load_idx = '0;
  logic [10:0] load_id = '0;
  logic [3:0]  load_dlc = '0;
  logic [7:0]  load_data = '0;
  logic        load_err;
  logic [3:0]  abort_req = '0;
  logic [3:0]  mb_pending, mb_done, mb_fail;
  logic        tx_ready = 1'b0;
  logic        tx_start;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        tx_ack_ok = 1'b0;
  logic        tx_arb_lost = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  can_tx_scheduler dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_idx(load_idx), .load_id(load_id),
    .load_dlc(load_dlc), .load_data(load_data), .load_err(load_err),
    .abort_req(abort_req), .mb_pending(mb_pending), .mb_done(mb_done), .mb_fail(mb_fail),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_id(tx_id), .tx_dlc(tx_dlc),
    .tx_data(tx_data), .tx_done(tx_done), .tx_ack_ok(tx_ack_ok),
    .tx_arb_lost(tx_arb_lost), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [2:0]  idx;
    logic [10:0] id;
    logic [3:0]  dlc;
    logic [7:0]  data;
    logic        exp_err;
    logic [3:0]  exp_pend;
    logic        exp_busy;
    logic [10:0] exp_txid;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic load(input logic [2:0] idx, input logic [10:0] id, input logic [3:0] dlc,
                      input logic [7:0] data);
    load_valid = 1'b1;
    load_idx   = idx;
    load_id    = id;
    load_dlc   = dlc;
    load_data  = data;
    step();
    load_valid = 1'b0;
  endtask

  task automatic wait_start(output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      cycles++;
      if (tx_start) seen = 1'b1;
    end
    check("tx_start_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic send_result(input logic ack, input logic arb, input logic [3:0] abrt);
    tx_done     = 1'b1;
    tx_ack_ok   = ack;
    tx_arb_lost = arb;
    abort_req   = abrt;
    step();
    tx_done     = 1'b0;
    tx_ack_ok   = 1'b0;
    tx_arb_lost = 1'b0;
    abort_req   = '0;
  endtask

  initial begin
    int n;

    // vld idx id dlc data | err pend busy txid
    vecs[0] = '{1'b1, 3'd1, 11'h300, 4'd3, 8'h11, 1'b0, 4'b0010, 1'b0, 11'h000};
    vecs[1] = '{1'b1, 3'd5, 11'h001, 4'd1, 8'hee, 1'b1, 4'b0010, 1'b1, 11'h000};
    vecs[2] = '{1'b1, 3'd7, 11'h001, 4'd1, 8'hee, 1'b1, 4'b0010, 1'b1, 11'h300};
    vecs[3] = '{1'b1, 3'd1, 11'h7ff, 4'd8, 8'hff, 1'b1, 4'b0010, 1'b1, 11'h300};
    vecs[4] = '{1'b1, 3'd0, 11'h100, 4'd2, 8'h00, 1'b0, 4'b0011, 1'b1, 11'h300};
    vecs[5] = '{1'b0, 3'd0, 11'h000, 4'd0, 8'h00, 1'b0, 4'b0011, 1'b1, 11'h300};
    vecs[6] = '{1'b1, 3'd3, 11'h050, 4'd4, 8'h33, 1'b0, 4'b1011, 1'b1, 11'h300};
    vecs[7] = '{1'b1, 3'd2, 11'h050, 4'd5, 8'h22, 1'b0, 4'b1111, 1'b1, 11'h300};

    do_reset();
    check("rst_pending", {28'd0, mb_pending}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_id", {21'd0, tx_id}, 32'd0);
    check("rst_load_err", {31'd0, load_err}, 32'd0);
    check("rst_done_fail", {24'd0, mb_done, mb_fail}, 32'd0);

    // Table: loads with tx_ready low so mb1 sits captured in LAUNCH.
    for (int v = 0; v < 8; v++) begin
      load_valid = vecs[v].vld;
      load_idx   = vecs[v].idx;
      load_id    = vecs[v].id;
      load_dlc   = vecs[v].dlc;
      load_data  = vecs[v].data;
      step();
      check($sformatf("vec%0d_load_err", v), {31'd0, load_err}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_pending", v), {28'd0, mb_pending}, {28'd0, vecs[v].exp_pend});
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].exp_busy});
      check($sformatf("vec%0d_tx_id", v), {21'd0, tx_id}, {21'd0, vecs[v].exp_txid});
    end
    load_valid = 1'b0;

    // Drain: mb1, then the 0x050 tie (mb2 before mb3), then mb0.
    tx_ready = 1'b1;
    wait_start(n);
    check("d_first_id", {21'd0, tx_id}, 32'h300);
    check("d_first_dlc", {28'd0, tx_dlc}, 32'd3);
    send_result(1'b1, 1'b0, 4'b0000);
    check("d_done_mb1", {28'd0, mb_done}, 32'b0010);
    wait_start(n);
    check("d_tie_id", {21'd0, tx_id}, 32'h050);
    check("d_tie_data", {24'd0, tx_data}, 32'h22);
    abort_req = 4'b0100;  // abort the in-flight mailbox, then ACK
    step();
    abort_req = '0;
    check("d_abort_deferred", {28'd0, mb_fail}, 32'd0);
    send_result(1'b1, 1'b0, 4'b0000);
    check("d_abort_ack_done", {28'd0, mb_done}, 32'b0100);
    check("d_abort_ack_nofail", {28'd0, mb_fail}, 32'd0);
    wait_start(n);
    check("d_mb3_data", {24'd0, tx_data}, 32'h33);
    send_result(1'b0, 1'b0, 4'b1000);  // abort with an error outcome
    check("d_abort_err_fail", {28'd0, mb_fail}, 32'b1000);
    check("d_abort_err_pend", {28'd0, mb_pending}, 32'b0001);
    wait_start(n);
    check("d_mb0_id", {21'd0, tx_id}, 32'h100);
    send_result(1'b1, 1'b0, 4'b0000);
    check("d_done_mb0", {28'd0, mb_done}, 32'b0001);
    check("d_empty", {28'd0, mb_pending}, 32'd0);

    // Priority: mb0 0x123 and mb2 0x0A5 loaded in the same idle period.
    do_reset();
    tx_ready = 1'b1;
    load(3'd0, 11'h123, 4'd1, 8'ha0);
    load(3'd2, 11'h0a5, 4'd1, 8'ha2);
    wait_start(n);
    check("p_first_id", {21'd0, tx_id}, 32'h0a5);
    send_result(1'b1, 1'b0, 4'b0000);
    check("p_done_mb2", {28'd0, mb_done}, 32'b0100);
    wait_start(n);
    check("p_second_id", {21'd0, tx_id}, 32'h123);
    send_result(1'b1, 1'b0, 4'b0000);
    check("p_done_mb0", {28'd0, mb_done}, 32'b0001);

    // Latency, arbitration loss x20, then retry limit on the same mailbox.
    do_reset();
    load(3'd1, 11'h200, 4'd2, 8'h5a);
    wait_start(n);
    check("latency", n, 32'd3);
    for (int k = 0; k < 20; k++) begin
      send_result(1'b0, 1'b1, 4'b0000);
      check("arb_no_fail", {28'd0, mb_fail}, 32'd0);
      wait_start(n);
      check("arb_relaunch_id", {21'd0, tx_id}, 32'h200);
    end
    for (int k = 1; k <= 8; k++) begin
      send_result(1'b0, 1'b0, 4'b0000);
      check($sformatf("retry%0d_fail", k), {28'd0, mb_fail}, (k == 8) ? 32'b0010 : 32'd0);
      if (k < 8) wait_start(n);
    end
    check("retry_pend_clear", {28'd0, mb_pending}, 32'd0);
    check("retry_no_done", {28'd0, mb_done}, 32'd0);

    // Abort of a non-in-flight mailbox; load beats abort on the same mailbox.
    do_reset();
    tx_ready = 1'b0;
    load(3'd0, 11'h001, 4'd1, 8'h01);
    load(3'd3, 11'h400, 4'd1, 8'h04);
    step();
    abort_req = 4'b1000;
    step();
    abort_req = '0;
    check("ab_fail_mb3", {28'd0, mb_fail}, 32'b1000);
    check("ab_pend", {28'd0, mb_pending}, 32'b0001);
    step();
    check("ab_fail_once", {28'd0, mb_fail}, 32'd0);
    abort_req = 4'b1000;
    load(3'd3, 11'h400, 4'd1, 8'h04);
    abort_req = '0;
    check("ab_load_wins_fail", {28'd0, mb_fail}, 32'd0);
    check("ab_load_wins_pend", {28'd0, mb_pending}, 32'b1001);

    // Reset while waiting for the result.
    tx_ready = 1'b1;
    wait_start(n);
    check("r_inflight_id", {21'd0, tx_id}, 32'h001);
    tx_ready = 1'b0;
    rst = 1'b0;
    step();
    check("r_pending", {28'd0, mb_pending}, 32'd0);
    check("r_busy", {31'd0, busy}, 32'd0);
    check("r_tx_id", {21'd0, tx_id}, 32'd0);
    check("r_outs", {26'd0, tx_start, load_err, mb_fail}, 32'd0);
    rst = 1'b1;
    step();
    check("r_no_fail_after", {28'd0, mb_fail}, 32'd0);
    check("r_idle_after", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
